// File: rtl/uart_link_pkg.sv
// Shared definitions for the host-side UART command link.
//   tx_state_t          : states of the response transmit FSM
//   CMD_BYTES_DEF       : default bytes per command word
//   TIMEOUT_CYCLES_DEF  : default inter-byte timeout in clk cycles
//   ACK_BYTE / NAK_BYTE : response codes used by the command dispatcher
package uart_link_pkg;

  localparam int CMD_BYTES_DEF      = 3;
  localparam int TIMEOUT_CYCLES_DEF = 500000;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// Response transmit path: takes one byte per valid/ready handshake from the
// dispatcher, strobes it into the UART transceiver and waits for the
// transceiver to report the byte as sent before accepting the next one.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   resp_valid/_data    : byte offered by the dispatcher
//   resp_ready          : high in TX_IDLE only
//   trmt                : one-cycle transmit strobe to the transceiver
//   tx_data             : byte being sent, held from trmt until tx_done
//   tx_done             : transceiver "byte sent" level
module uart_resp_tx
  import uart_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_valid,
  input  logic [7:0] resp_data,
  output logic       resp_ready,
  output logic       trmt,
  output logic [7:0] tx_data,
  input  logic       tx_done
);

  tx_state_t  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_done_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_done_q <= tx_done;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    resp_ready = 1'b0;
    trmt       = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          tx_data_d = resp_data;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        trmt    = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        // Only a fresh rising edge counts; a level left high from the
        // previous byte is stale and must not end the wait.
        if (tx_done && !tx_done_q) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data = tx_data_q;

endmodule

// File: rtl/uart_cmd_link.sv
// Host-facing end of the scope UART link.
// RX: acknowledges each received byte with a one-cycle clr_rdy and packs
// CMD_BYTES bytes, first byte in the MSBs, into cmd. cmd_rdy holds until the
// dispatcher pulses clr_cmd_rdy; no bytes are taken while it is high. A
// partial command idle for TIMEOUT_CYCLES is dropped with a frame_err pulse.
// TX: delegated to uart_resp_tx.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   rdy, rx_data, clr_rdy : transceiver receive handshake
//   trmt, tx_data, tx_done: transceiver transmit handshake
//   cmd, cmd_rdy, clr_cmd_rdy : command word to dispatcher
//   resp_valid, resp_data, resp_ready : response byte from dispatcher
//   frame_err             : one-cycle pulse on inter-byte timeout
module uart_cmd_link
  import uart_link_pkg::*;
#(
  parameter int CMD_BYTES      = CMD_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rdy,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   resp_valid,
  input  logic [7:0]             resp_data,
  output logic                   resp_ready,
  output logic                   frame_err
);

  localparam int CMD_W = 8 * CMD_BYTES;
  localparam int CNT_W = $clog2(CMD_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CMD_W-1:0] shift_q, shift_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             clr_rdy_q, frame_err_q;

  logic             accept, last_byte, timeout;
  logic [CMD_W-1:0] assembled;

  // clr_rdy_q masks the cycle in which the transceiver is still clearing rdy,
  // so one byte is never captured twice.
  assign accept    = rdy && !clr_rdy_q && !cmd_rdy_q;
  assign last_byte = (cnt_q == CNT_W'(CMD_BYTES - 1));
  assign timeout   = (cnt_q != '0) && !accept &&
                     (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign assembled = (shift_q << 8) | CMD_W'(rx_data);

  always_comb begin
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (accept) begin
      shift_d = assembled;
      timer_d = '0;
      if (last_byte) begin
        cmd_d     = assembled;
        cmd_rdy_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (timeout) begin
      shift_d = '0;
      cnt_d   = '0;
      timer_d = '0;
    end else if (cnt_q != '0) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      cmd_rdy_q   <= 1'b0;
      clr_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      cmd_rdy_q   <= cmd_rdy_d;
      clr_rdy_q   <= accept;
      frame_err_q <= timeout;
    end
  end

  assign clr_rdy   = clr_rdy_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;

  uart_resp_tx u_resp_tx (
    .clk        (clk),
    .rst        (rst),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

endmodule

// File: tb/tb_uart_cmd_link.sv
// Scoreboard bench for uart_cmd_link (CMD_BYTES=3, TIMEOUT_CYCLES=100).
// Stimulus pushes expected command words / response bytes into queues; a
// monitor pops and compares when the DUT raises cmd_rdy or trmt.
module tb_uart_cmd_link;
  import uart_link_pkg::*;

  localparam int NB = 3;
  localparam int T  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rdy, trmt, cmd_rdy, resp_ready, frame_err;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b1;
  logic [23:0] cmd;
  logic        clr_cmd_rdy = 1'b0;
  logic        resp_valid = 1'b0;
  logic [7:0]  resp_data = '0;

  uart_cmd_link #(.CMD_BYTES(NB), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .cmd(cmd),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_ready(resp_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  partial[$];
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [23:0] last_cmd = '0;
  int bytes_sent = 0, frame_exp = 0, resp_sent = 0;

  function automatic void model_accept(input logic [7:0] b);
    int unsigned w;
    partial.push_back(b);
    bytes_sent++;
    if (partial.size() == NB) begin
      w = 0;
      foreach (partial[i]) w += int'(partial[i]) * (256 ** (NB - 1 - i));
      exp_cmd_q.push_back(w[23:0]);
      last_cmd = w[23:0];
      partial.delete();
    end
  endfunction

  function automatic void model_timeout();
    partial.delete();
    frame_exp++;
  endfunction

  // ---------------- monitor ----------------
  logic clr_prev = 0, frame_prev = 0, cmd_rdy_prev = 0, trmt_prev = 0;
  logic [7:0] tx_cur = '0;
  int clr_pulses = 0, frame_seen = 0, trmt_seen = 0, frame_cyc = 0;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      clr_prev = 0; frame_prev = 0; cmd_rdy_prev = 0; trmt_prev = 0;
    end else begin
      if (clr_rdy) begin
        check("clr_rdy_single_cycle", 32'(clr_prev), 0);
        if (!clr_prev) clr_pulses++;
      end
      if (frame_err) begin
        check("frame_err_single_cycle", 32'(frame_prev), 0);
        check("cmd_kept_on_timeout", 32'(cmd), 32'(last_cmd));
        if (!frame_prev) begin
          frame_seen++;
          frame_cyc = cyc;
        end
      end
      if (cmd_rdy && !cmd_rdy_prev) begin
        check("cmd_expected", 32'(exp_cmd_q.size() != 0), 1);
        if (exp_cmd_q.size() != 0) check("cmd_word", 32'(cmd), 32'(exp_cmd_q.pop_front()));
      end
      if (trmt) begin
        check("trmt_single_cycle", 32'(trmt_prev), 0);
        check("trmt_only_when_tx_idle", 32'(tx_done), 1);
        check("tx_expected", 32'(tx_exp_q.size() != 0), 1);
        if (tx_exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
        tx_cur = tx_data;
        trmt_seen++;
      end else if (!resp_ready) begin
        check("tx_data_stable_in_wait", 32'(tx_data), 32'(tx_cur));
      end
      clr_prev = clr_rdy; frame_prev = frame_err;
      cmd_rdy_prev = cmd_rdy; trmt_prev = trmt;
    end
  end

  // ---------------- dispatcher consumer ----------------
  bit cons_en = 0, cons_fast = 0;
  always begin
    @(negedge clk);
    if (cons_en && cmd_rdy && !rst) begin
      if (!cons_fast) repeat ($urandom_range(0, 4)) @(posedge clk);
      @(posedge clk); #1 clr_cmd_rdy = 1'b1;
      @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    end
  end

  // ---------------- transceiver TX model ----------------
  int rst_count = 0;
  bit tx_hold = 0;
  always begin
    @(negedge clk);
    if (trmt && !rst) begin
      int rc, d0, fr;
      rc = rst_count;
      d0 = int'($urandom_range(0, 2));
      fr = int'($urandom_range(2, 8));
      // tx_done stays high for d0 cycles after trmt: a stale level.
      repeat (d0) @(posedge clk);
      @(posedge clk); #1 tx_done = 1'b0;
      repeat (fr) @(posedge clk);
      while (tx_hold) @(posedge clk);
      #1 tx_done = 1'b1;
      @(negedge clk); #2;
      if (rc == rst_count) check("resp_ready_low_at_done_rise", 32'(resp_ready), 0);
      @(negedge clk); #2;
      if (rc == rst_count) check("resp_ready_after_done_rise", 32'(resp_ready), 1);
    end
  end

  // ---------------- drivers ----------------
  int last_accept_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit is_last;
    int waited;
    is_last = (partial.size() == NB - 1);
    waited = 0;
    @(posedge clk); #1;
    rdy = 1'b1; rx_data = b;
    forever begin
      @(negedge clk);
      if (clr_rdy) break;
      waited++;
      if (waited > 400) begin
        check("rx_accept_timeout", 32'(clr_rdy), 1);
        rdy = 1'b0;
        return;
      end
    end
    check("cmd_rdy_at_accept", 32'(cmd_rdy), 32'(is_last));
    last_accept_cyc = cyc;
    model_accept(b);
    // rdy held through the clr_rdy cycle, as a real transceiver would.
    @(posedge clk); #1 rdy = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_resp(input logic [7:0] b);
    int waited;
    waited = 0;
    resp_valid = 1'b1; resp_data = b;
    forever begin
      @(negedge clk);
      if (resp_ready) break;
      waited++;
      if (waited > 200) begin
        check("resp_handshake_timeout", 32'(resp_ready), 1);
        resp_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    tx_exp_q.push_back(b);
    resp_sent++;
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_cmd_q.size() != 0 || cmd_rdy || tx_exp_q.size() != 0 || !resp_ready) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_cmd_queue", 32'(exp_cmd_q.size()), 0);
    check("drain_tx_queue", 32'(tx_exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, start, gap;
    bit seen;

    #12;
    check("rst_clr_rdy", 32'(clr_rdy), 0);
    check("rst_trmt", 32'(trmt), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_resp_ready", 32'(resp_ready), 1);
    @(negedge clk) rst = 1'b0;
    cons_en = 1;

    // Basic command assembly.
    send_byte(8'h12, 0);
    send_byte(8'h34, 2);
    send_byte(8'h56, 0);
    drain();
    check("three_clr_rdy_pulses", 32'(clr_pulses), 3);

    // Inter-byte timeout: frame_err exactly T cycles after the clr_rdy cycle.
    base = frame_seen;
    send_byte(8'hAA, 0);
    start = last_accept_cyc;
    repeat (T + 10) @(posedge clk);
    model_timeout();
    check("timeout_frame_err_count", 32'(frame_seen - base), 1);
    check("timeout_frame_err_cycle", 32'(frame_cyc - start), T);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    drain();

    // Backpressure while cmd_rdy is pending.
    cons_en = 0;
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), 1);
    @(posedge clk); #1;
    rdy = 1'b1; rx_data = 8'h77;
    base = clr_pulses;
    repeat (30) @(negedge clk);
    check("backpressure_no_clr_rdy", 32'(clr_pulses - base), 0);
    check("backpressure_cmd_rdy_held", 32'(cmd_rdy), 1);
    cons_fast = 1; cons_en = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = clr_cmd_rdy;
    end
    @(negedge clk);
    check("cmd_rdy_cleared", 32'(cmd_rdy), 0);
    check("no_accept_same_cycle", 32'(clr_rdy), 0);
    @(negedge clk);
    check("accept_after_clear", 32'(clr_rdy), 1);
    model_accept(8'h77);
    @(posedge clk); #1 rdy = 1'b0;
    cons_fast = 0;
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    drain();

    // Concurrent randomized RX and TX traffic.
    fork
      begin
        @(posedge clk); #1;
        send_resp(ACK_BYTE);
        send_resp(NAK_BYTE);
        for (int i = 0; i < 25; i++) begin
          gap = int'($urandom_range(0, 6));
          if (gap > 0) begin
            resp_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
          end
          send_resp(8'($urandom));
        end
        resp_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          for (int i = 0; i < NB; i++) begin
            send_byte(8'($urandom), int'($urandom_range(0, 30)));
            if (i < NB - 1 && $urandom_range(0, 9) == 0) begin
              repeat (T + 20) @(posedge clk);
              model_timeout();
              break;
            end
          end
        end
      end
    join
    drain();

    // Asynchronous reset mid-command and during TX_WAIT.
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tx_hold = 1;
    @(posedge clk); #1;
    send_resp(8'h5A);
    resp_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    rst_count++;
    #1;
    check("arst_clr_rdy", 32'(clr_rdy), 0);
    check("arst_trmt", 32'(trmt), 0);
    check("arst_tx_data", 32'(tx_data), 0);
    check("arst_cmd", 32'(cmd), 0);
    check("arst_cmd_rdy", 32'(cmd_rdy), 0);
    check("arst_frame_err", 32'(frame_err), 0);
    check("arst_resp_ready", 32'(resp_ready), 1);
    partial.delete();
    tx_exp_q.delete();
    last_cmd = '0;
    @(negedge clk) rst = 1'b0;
    tx_hold = 0;
    repeat (15) @(posedge clk);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    drain();
    check("cmd_after_reset", 32'(cmd), 32'h00DEADBE);

    check("total_clr_rdy_pulses", 32'(clr_pulses), 32'(bytes_sent));
    check("total_frame_err", 32'(frame_seen), 32'(frame_exp));
    check("total_trmt", 32'(trmt_seen), 32'(resp_sent));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_link.md
Name: uart_cmd_link

Overview:
- Host-facing end of the scope's UART link; the client side of the UART transceiver's byte handshake in both directions.
- RX path: consumes the transceiver's rdy/rx_data bytes, returns a one-cycle clr_rdy per byte, and assembles CMD_BYTES bytes MSB-first into one command word for the scope command dispatcher.
- TX path: accepts single response bytes from the dispatcher, issues trmt/tx_data to the transceiver, and waits for tx_done before accepting the next byte.

Parameters:
CMD_BYTES, 3, bytes per command; cmd width = 8*CMD_BYTES.
TIMEOUT_CYCLES, 500000, max clk cycles between bytes of one command before the partial command is discarded.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rdy  input  1  transceiver: received byte valid, held until cleared
rx_data  input  8  transceiver: received byte
clr_rdy  output  1  to transceiver: one-cycle acknowledge of rx byte
trmt  output  1  to transceiver: one-cycle transmit strobe
tx_data  output  8  to transceiver: byte to send, stable from trmt until tx_done
tx_done  input  1  transceiver: byte sent, level, cleared by transceiver on trmt
cmd  output  8*CMD_BYTES  assembled command, first byte in MSBs
cmd_rdy  output  1  cmd valid, held until clr_cmd_rdy
clr_cmd_rdy  input  1  dispatcher consumed cmd
resp_valid  input  1  dispatcher offers resp_data
resp_data  input  8  response byte
resp_ready  output  1  high when a response byte can be accepted
frame_err  output  1  one-cycle pulse on inter-byte timeout

Behaviour:
- Reset (async, rst=1): clr_rdy=0, trmt=0, tx_data=0, cmd=0, cmd_rdy=0, frame_err=0. Byte count=0, timer=0, TX FSM=TX_IDLE, so resp_ready=1.
- Byte accept condition: rdy & ~clr_rdy & ~cmd_rdy.
  - On accept: the byte is shifted into the assembly register.
  - clr_rdy is registered high for exactly the next cycle.
  - Byte count increments.
- While clr_rdy=1, rdy is ignored; no double capture.
- While cmd_rdy=1, no bytes are accepted. rdy stays unacknowledged (backpressure); clr_rdy stays 0.
- Command completion: when the accepted byte is byte CMD_BYTES-1:
  - cmd loads the full assembled word.
  - cmd_rdy=1 on the following cycle.
  - Byte count returns to 0.
- cmd holds its value until the next completion.
- clr_cmd_rdy=1 clears cmd_rdy on the next edge. If clr_cmd_rdy coincides with a pending rdy, the byte is accepted one cycle later.
- Inter-byte timeout:
  - The timer runs only while byte count>0 and no byte is accepted; it resets to 0 on every accept.
  - When the timer reaches TIMEOUT_CYCLES-1: byte count=0, partial data discarded, frame_err=1 for one cycle, cmd/cmd_rdy unchanged.
  - Timer width is clog2(TIMEOUT_CYCLES+1).
- TX FSM states: TX_IDLE, TX_START, TX_WAIT.
  - TX_IDLE: resp_ready=1. resp_valid=1 latches resp_data into tx_data and moves to TX_START.
  - TX_START: trmt=1 for this single cycle, then TX_WAIT.
  - TX_WAIT: wait for a rising edge of tx_done (registered tx_done_q=0, tx_done=1), then TX_IDLE.
  - A tx_done already high when entering TX_START/TX_WAIT is stale and ignored.
- resp_ready = (state==TX_IDLE), combinational from state. Handshake is valid&ready, one byte per handshake. Minimum 3 cycles between trmt strobes plus transceiver frame time.
- RX and TX paths are independent; simultaneous activity is legal.
- Reset mid-operation: partial command discarded and TX FSM returns to TX_IDLE. Any byte already in the transceiver is not retracted.

Decomposition:
- Package uart_link_pkg:
  - tx_state_t enum (TX_IDLE, TX_START, TX_WAIT)
  - CMD_BYTES/TIMEOUT_CYCLES defaults
  - localparam ACK_BYTE=8'hA5, NAK_BYTE=8'hEE for dispatcher use
- One natural sub-module: uart_resp_tx, holding the TX FSM, tx_data latch and tx_done edge detect. The RX assembler and timer stay in the top module.

Test Plan:
- Bytes 0x12,0x34,0x56 via rdy (transceiver model clears rdy the cycle after clr_rdy) -> exactly three one-cycle clr_rdy pulses; cmd=0x123456, cmd_rdy=1 one cycle after the third accept.
- TIMEOUT_CYCLES=100: send 0xAA, idle 100 cycles -> frame_err single pulse, cmd unchanged. Then 0x01,0x02,0x03 -> cmd=0x010203.
- cmd_rdy=1 with a 4th byte 0x77 on rdy -> clr_rdy stays 0 indefinitely. Pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, 0x77 accepted the cycle after, with a single clr_rdy.
- resp_valid with resp_data=0xA5 while tx_done held high (stale) -> tx_data=0xA5, one-cycle trmt, resp_ready=0 until tx_done falls then rises; back to 1 the cycle after the rise.
- Back-to-back responses 0xA5,0xEE with resp_valid held -> two trmt pulses, second only after the first tx_done rise; tx_data never changes while in TX_WAIT.
- rst asserted after 2 of 3 bytes and during TX_WAIT -> all outputs at reset values immediately (async). Then 3 fresh bytes 0xDE,0xAD,0xBE -> cmd=0xDEADBE.
